// File: rtl/gpc_c2f_req_arb.sv
// Round-robin arbiter for the shared C2F request channel with per-thread outstanding tracking.
// Optional watchdog on pending threads is enabled by defining GPC_C2F_TIMEOUT_EN.
module gpc_c2f_req_arb #(
  parameter int NUM_TH  = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic                       QClk,
  input  logic                       RstQnnnL,
  input  logic [NUM_TH-1:0]          ThReqValidQ500H,
  input  logic [NUM_TH*2-1:0]        ThReqOpcodeQ500H,
  input  logic [NUM_TH*ADDR_W-1:0]   ThReqAddressQ500H,
  input  logic [NUM_TH*DATA_W-1:0]   ThReqDataQ500H,
  output logic [NUM_TH-1:0]          ThReqGntQ500H,
  output logic [NUM_TH-1:0]          ThPendingQ,
  output logic [NUM_TH-1:0]          ThRspValidQ502H,
  output logic [DATA_W-1:0]          ThRspDataQ502H,
  output logic                       C2F_ReqValidQ500H,
  output logic [1:0]                 C2F_ReqOpcodeQ500H,
  output logic [1:0]                 C2F_ReqThreadIDQ500H,
  output logic [ADDR_W-1:0]          C2F_ReqAddressQ500H,
  output logic [DATA_W-1:0]          C2F_ReqDataQ500H,
  input  logic                       C2F_RspValidQ502H,
  input  logic [1:0]                 C2F_RspOpcodeQ502H,
  input  logic [1:0]                 C2F_RspThreadIDQ502H,
  input  logic [DATA_W-1:0]          C2F_RspDataQ502H,
  input  logic                       C2F_RspStall,
  output logic                       ArbErrQ
);

  typedef enum logic {TH_IDLE = 1'b0, TH_PENDING = 1'b1} th_state_e;

  th_state_e [NUM_TH-1:0] st_q, st_d;
  logic [NUM_TH-1:0][1:0] op_q, op_d;
  logic [1:0]             ptr_q, ptr_d;
  logic                   err_q, err_d;
  logic                   vld_q, vld_d;
  logic [1:0]             opc_q, opc_d;
  logic [1:0]             tid_q, tid_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      data_q, data_d;

  logic [NUM_TH-1:0]      pending;
  logic [NUM_TH-1:0]      legal;
  logic [NUM_TH-1:0]      elig;
  logic [NUM_TH-1:0]      gnt;
  logic [1:0]             gnt_idx;
  logic                   gnt_any;
  logic                   rsp_hit;
  logic [NUM_TH-1:0]      rsp_clr;
  logic [NUM_TH-1:0]      tmo_fire;

  always_comb begin
    for (int i = 0; i < NUM_TH; i++) begin
      pending[i] = (st_q[i] == TH_PENDING);
      legal[i]   = (ThReqOpcodeQ500H[2*i +: 2] == 2'b01) ||
                   (ThReqOpcodeQ500H[2*i +: 2] == 2'b10);
    end
  end

  assign elig = ThReqValidQ500H & ~pending & legal & {NUM_TH{~C2F_RspStall}};

  // Search starts at the pointer and wraps, so the most recently served thread goes last.
  always_comb begin
    logic [1:0] idx;
    gnt_idx = 2'd0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_TH; k++) begin
      idx = ptr_q + 2'(k);
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign rsp_hit = C2F_RspValidQ502H && pending[C2F_RspThreadIDQ502H];

  always_comb begin
    rsp_clr = '0;
    if (rsp_hit) rsp_clr[C2F_RspThreadIDQ502H] = 1'b1;
  end

`ifdef GPC_C2F_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TMO_CYC);
  logic [NUM_TH-1:0][7:0] cnt_q, cnt_d;

  // A real response owns the response bus; an expired thread waits one more cycle.
  always_comb begin
    logic fired;
    fired    = 1'b0;
    tmo_fire = '0;
    for (int i = 0; i < NUM_TH; i++) begin
      if (!rsp_hit && !fired && pending[i] && (cnt_q[i] >= TMO_LIM)) begin
        tmo_fire[i] = 1'b1;
        fired       = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_TH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt[i])                               cnt_d[i] = 8'd0;
      else if (pending[i] && cnt_q[i] != 8'hFF) cnt_d[i] = cnt_q[i] + 8'd1;
    end
  end

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end
`else
  assign tmo_fire = '0;
`endif

  always_comb begin
    st_d   = st_q;
    op_d   = op_q;
    ptr_d  = ptr_q;
    vld_d  = 1'b0;
    opc_d  = 2'b00;
    tid_d  = 2'd0;
    addr_d = '0;
    data_d = '0;
    for (int i = 0; i < NUM_TH; i++) begin
      if (gnt[i]) begin
        st_d[i] = TH_PENDING;
        op_d[i] = ThReqOpcodeQ500H[2*i +: 2];
      end else if (rsp_clr[i] || tmo_fire[i]) begin
        st_d[i] = TH_IDLE;
      end
    end
    if (gnt_any) begin
      ptr_d  = gnt_idx + 2'd1;
      vld_d  = 1'b1;
      opc_d  = ThReqOpcodeQ500H[2*gnt_idx +: 2];
      tid_d  = gnt_idx;
      addr_d = ThReqAddressQ500H[ADDR_W*gnt_idx +: ADDR_W];
      data_d = ThReqDataQ500H[DATA_W*gnt_idx +: DATA_W];
    end
    err_d = err_q
          | (C2F_RspValidQ502H && !pending[C2F_RspThreadIDQ502H])
          | (rsp_hit && (C2F_RspOpcodeQ502H != op_q[C2F_RspThreadIDQ502H]))
          | (|(ThReqValidQ500H & ~legal))
          | (|tmo_fire);
  end

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      st_q   <= {NUM_TH{TH_IDLE}};
      op_q   <= '0;
      ptr_q  <= 2'd0;
      err_q  <= 1'b0;
      vld_q  <= 1'b0;
      opc_q  <= 2'b00;
      tid_q  <= 2'd0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      st_q   <= st_d;
      op_q   <= op_d;
      ptr_q  <= ptr_d;
      err_q  <= err_d;
      vld_q  <= vld_d;
      opc_q  <= opc_d;
      tid_q  <= tid_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign ThReqGntQ500H        = gnt;
  assign ThPendingQ           = pending;
  assign ThRspValidQ502H      = rsp_clr | tmo_fire;
  assign ThRspDataQ502H       = rsp_hit ? C2F_RspDataQ502H :
                                (|tmo_fire) ? DATA_W'(32'hDEAD_BEEF) : '0;
  assign C2F_ReqValidQ500H    = vld_q;
  assign C2F_ReqOpcodeQ500H   = opc_q;
  assign C2F_ReqThreadIDQ500H = tid_q;
  assign C2F_ReqAddressQ500H  = addr_q;
  assign C2F_ReqDataQ500H     = data_q;
  assign ArbErrQ              = err_q;

endmodule

// File: tb/tb_gpc_c2f_req_arb.sv
// Directed bench for gpc_c2f_req_arb: grant order, launch timing, stall, response and error paths.
module tb_gpc_c2f_req_arb;

`ifdef GPC_C2F_TIMEOUT_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 255;
`endif

  logic         clk;
  logic         rst_n;
  logic [3:0]   th_req_valid;
  logic [7:0]   th_req_op;
  logic [127:0] th_req_addr;
  logic [127:0] th_req_data;
  logic [3:0]   th_gnt;
  logic [3:0]   th_pending;
  logic [3:0]   th_rsp_valid;
  logic [31:0]  th_rsp_data;
  logic         c2f_req_valid;
  logic [1:0]   c2f_req_op;
  logic [1:0]   c2f_req_tid;
  logic [31:0]  c2f_req_addr;
  logic [31:0]  c2f_req_data;
  logic         c2f_rsp_valid;
  logic [1:0]   c2f_rsp_op;
  logic [1:0]   c2f_rsp_tid;
  logic [31:0]  c2f_rsp_data;
  logic         c2f_rsp_stall;
  logic         arb_err;

  int n_tests = 0;
  int n_fail  = 0;

  gpc_c2f_req_arb #(.TMO_CYC(TB_TMO)) dut (
    .QClk                 (clk),
    .RstQnnnL             (rst_n),
    .ThReqValidQ500H      (th_req_valid),
    .ThReqOpcodeQ500H     (th_req_op),
    .ThReqAddressQ500H    (th_req_addr),
    .ThReqDataQ500H       (th_req_data),
    .ThReqGntQ500H        (th_gnt),
    .ThPendingQ           (th_pending),
    .ThRspValidQ502H      (th_rsp_valid),
    .ThRspDataQ502H       (th_rsp_data),
    .C2F_ReqValidQ500H    (c2f_req_valid),
    .C2F_ReqOpcodeQ500H   (c2f_req_op),
    .C2F_ReqThreadIDQ500H (c2f_req_tid),
    .C2F_ReqAddressQ500H  (c2f_req_addr),
    .C2F_ReqDataQ500H     (c2f_req_data),
    .C2F_RspValidQ502H    (c2f_rsp_valid),
    .C2F_RspOpcodeQ502H   (c2f_rsp_op),
    .C2F_RspThreadIDQ502H (c2f_rsp_tid),
    .C2F_RspDataQ502H     (c2f_rsp_data),
    .C2F_RspStall         (c2f_rsp_stall),
    .ArbErrQ              (arb_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input int t, input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] data);
    th_req_valid[t]          = 1'b1;
    th_req_op[2*t +: 2]      = op;
    th_req_addr[32*t +: 32]  = addr;
    th_req_data[32*t +: 32]  = data;
  endtask

  task automatic set_rsp(input logic [1:0] tid, input logic [1:0] op, input logic [31:0] data);
    c2f_rsp_valid = 1'b1;
    c2f_rsp_tid   = tid;
    c2f_rsp_op    = op;
    c2f_rsp_data  = data;
  endtask

  task automatic clr_rsp();
    c2f_rsp_valid = 1'b0;
    c2f_rsp_tid   = 2'd0;
    c2f_rsp_op    = 2'd0;
    c2f_rsp_data  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_pending", 64'(th_pending), 64'h0);
    check("rst_c2f_valid", 64'(c2f_req_valid), 64'h0);
    check("rst_err", 64'(arb_err), 64'h0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    th_req_valid  = '0;
    th_req_op     = '0;
    th_req_addr   = '0;
    th_req_data   = '0;
    c2f_rsp_stall = 1'b0;
    clr_rsp();

    // reset state
    #2;
    check("rst_gnt", 64'(th_gnt), 64'h0);
    check("rst_rsp_valid", 64'(th_rsp_valid), 64'h0);
    check("rst_rsp_data", 64'(th_rsp_data), 64'h0);
    check("rst_c2f_addr", 64'(c2f_req_addr), 64'h0);
    do_reset();

    // all four threads request RD at once
    tick();
    for (int t = 0; t < 4; t++) set_req(t, 2'b01, 32'h100 + 32'(t), 32'h0);
    settle();
    check("rr_gnt0", 64'(th_gnt), 64'h1);
    for (int t = 1; t < 4; t++) begin
      tick();
      th_req_valid[t-1] = 1'b0;
      settle();
      check("rr_gnt", 64'(th_gnt), 64'(4'b0001 << t));
      check("rr_c2f_valid", 64'(c2f_req_valid), 64'h1);
      check("rr_c2f_tid", 64'(c2f_req_tid), 64'(t - 1));
      check("rr_c2f_addr", 64'(c2f_req_addr), 64'(32'h100 + 32'(t - 1)));
    end
    tick();
    th_req_valid = '0;
    settle();
    check("rr_gnt_none", 64'(th_gnt), 64'h0);
    check("rr_c2f_tid3", 64'(c2f_req_tid), 64'h3);
    check("rr_pending_all", 64'(th_pending), 64'hF);
    tick();
    settle();
    check("rr_c2f_idle", 64'(c2f_req_valid), 64'h0);
    check("rr_c2f_idle_addr", 64'(c2f_req_addr), 64'h0);

    // return RD data to every thread
    for (int t = 0; t < 4; t++) begin
      tick();
      set_rsp(2'(t), 2'b01, 32'h1000 + 32'(t));
      settle();
      check("rd_rsp_valid", 64'(th_rsp_valid), 64'(4'b0001 << t));
      check("rd_rsp_data", 64'(th_rsp_data), 64'(32'h1000 + 32'(t)));
    end
    tick();
    clr_rsp();
    settle();
    check("rd_pending_clear", 64'(th_pending), 64'h0);

    // T2 write
    tick();
    set_req(2, 2'b10, 32'h0040_0F04, 32'h5);
    settle();
    check("wr_gnt", 64'(th_gnt), 64'h4);
    tick();
    th_req_valid = '0;
    settle();
    check("wr_c2f_valid", 64'(c2f_req_valid), 64'h1);
    check("wr_c2f_op", 64'(c2f_req_op), 64'h2);
    check("wr_c2f_tid", 64'(c2f_req_tid), 64'h2);
    check("wr_c2f_addr", 64'(c2f_req_addr), 64'h0040_0F04);
    check("wr_c2f_data", 64'(c2f_req_data), 64'h5);
    check("wr_pending", 64'(th_pending), 64'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      check("wr_pending_hold", 64'(th_pending), 64'h4);
      check("wr_no_rsp", 64'(th_rsp_valid), 64'h0);
    end
    tick();
    set_rsp(2'd2, 2'b10, 32'h0);
    settle();
    check("wr_ack_valid", 64'(th_rsp_valid), 64'h4);
    tick();
    clr_rsp();
    settle();
    check("wr_pending_done", 64'(th_pending), 64'h0);

    // stall blocks T1 for five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        c2f_rsp_stall = 1'b1;
        set_req(1, 2'b01, 32'h200, 32'h0);
      end
      settle();
      check("stall_gnt", 64'(th_gnt), 64'h0);
    end
    tick();
    c2f_rsp_stall = 1'b0;
    settle();
    check("stall_release_gnt", 64'(th_gnt), 64'h2);
    tick();
    th_req_valid = '0;
    settle();
    check("stall_c2f_tid", 64'(c2f_req_tid), 64'h1);
    check("stall_pending", 64'(th_pending), 64'h2);

    // T0 response and new T0 request in the same cycle
    tick();
    set_req(0, 2'b01, 32'h300, 32'h0);
    settle();
    check("same_gnt_first", 64'(th_gnt), 64'h1);
    tick();
    set_rsp(2'd0, 2'b01, 32'h77);
    settle();
    check("same_rsp_valid", 64'(th_rsp_valid), 64'h1);
    check("same_rsp_data", 64'(th_rsp_data), 64'h77);
    check("same_no_gnt", 64'(th_gnt), 64'h0);
    tick();
    clr_rsp();
    settle();
    check("same_gnt_next", 64'(th_gnt), 64'h1);
    tick();
    th_req_valid = '0;
    set_rsp(2'd1, 2'b01, 32'h88);
    settle();
    check("t1_rsp_valid", 64'(th_rsp_valid), 64'h2);
    tick();
    set_rsp(2'd0, 2'b01, 32'h99);
    settle();
    check("t0_rsp_valid", 64'(th_rsp_valid), 64'h1);
    tick();
    clr_rsp();
    settle();
    check("drain_pending", 64'(th_pending), 64'h0);
    check("no_err_yet", 64'(arb_err), 64'h0);

    // response to an idle thread
    tick();
    set_rsp(2'd3, 2'b01, 32'h55);
    settle();
    check("idle_rsp_dropped", 64'(th_rsp_valid), 64'h0);
    tick();
    clr_rsp();
    settle();
    check("idle_rsp_err", 64'(arb_err), 64'h1);
    tick();
    tick();
    settle();
    check("err_sticky", 64'(arb_err), 64'h1);

    // reset mid-transaction, then a late response
    tick();
    set_req(0, 2'b01, 32'h400, 32'h0);
    settle();
    check("mid_gnt", 64'(th_gnt), 64'h1);
    tick();
    th_req_valid = '0;
    settle();
    check("mid_pending", 64'(th_pending), 64'h1);
    do_reset();
    tick();
    set_rsp(2'd0, 2'b01, 32'h66);
    settle();
    check("late_rsp_dropped", 64'(th_rsp_valid), 64'h0);
    tick();
    clr_rsp();
    settle();
    check("late_rsp_err", 64'(arb_err), 64'h1);

    // illegal opcode is never granted
    do_reset();
    tick();
    set_req(1, 2'b11, 32'h500, 32'h0);
    settle();
    check("illegal_gnt", 64'(th_gnt), 64'h0);
    tick();
    th_req_valid = '0;
    settle();
    check("illegal_err", 64'(arb_err), 64'h1);
    check("illegal_no_launch", 64'(c2f_req_valid), 64'h0);

`ifdef GPC_C2F_TIMEOUT_EN
    // watchdog on an unanswered T1
    do_reset();
    tick();
    set_req(1, 2'b01, 32'h600, 32'h0);
    settle();
    check("tmo_gnt", 64'(th_gnt), 64'h2);
    tick();
    th_req_valid = '0;
    for (int i = 0; i < 16; i++) begin
      settle();
      check("tmo_wait", 64'(th_rsp_valid), 64'h0);
      tick();
    end
    settle();
    check("tmo_rsp_valid", 64'(th_rsp_valid), 64'h2);
    check("tmo_rsp_data", 64'(th_rsp_data), 64'hDEADBEEF);
    tick();
    set_req(1, 2'b01, 32'h600, 32'h0);
    settle();
    check("tmo_err", 64'(arb_err), 64'h1);
    check("tmo_regrant", 64'(th_gnt), 64'h2);
    tick();
    th_req_valid = '0;
`endif

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/gpc_c2f_req_arb.md
Name: gpc_c2f_req_arb

Overview:
Round-robin arbiter and outstanding-request tracker that shares the single core-to-fabric (C2F) request channel of the 4-thread GPC between its hardware threads.
- Each thread raises a request.
- The arbiter grants one thread per cycle and launches it on the registered C2F channel.
- It holds the thread pending until the fabric response with a matching ThreadID returns, then hands the response back to that thread.
- Sits between core_4t memory-stage request logic and the C2F_* ports of gpc_4t.

Parameters:
NUM_TH, 4, number of hardware threads (ThreadID width = 2; only 4 supported).
ADDR_W, 32, request address width.
DATA_W, 32, request/response data width.
TMO_CYC, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
QClk  in  1  core clock.
RstQnnnL  in  1  asynchronous active-low reset.
ThReqValidQ500H  in  4  per-thread request valid; held until granted.
ThReqOpcodeQ500H  in  4x2  per-thread opcode: 01=RD, 10=WR; 00 and 11 illegal.
ThReqAddressQ500H  in  4xADDR_W  per-thread address.
ThReqDataQ500H  in  4xDATA_W  per-thread write data.
ThReqGntQ500H  out  4  one-hot grant, combinational, same cycle as valid.
ThPendingQ  out  4  thread has an outstanding request.
ThRspValidQ502H  out  4  one-hot response delivery.
ThRspDataQ502H  out  DATA_W  response data for the thread flagged in ThRspValidQ502H.
C2F_ReqValidQ500H  out  1  fabric request valid (registered).
C2F_ReqOpcodeQ500H  out  2  fabric request opcode.
C2F_ReqThreadIDQ500H  out  2  granted thread index.
C2F_ReqAddressQ500H  out  ADDR_W  fabric request address.
C2F_ReqDataQ500H  out  DATA_W  fabric request data.
C2F_RspValidQ502H  in  1  fabric response valid.
C2F_RspOpcodeQ502H  in  2  01=RD data, 10=WR ack.
C2F_RspThreadIDQ502H  in  2  responding thread.
C2F_RspDataQ502H  in  DATA_W  response data.
C2F_RspStall  in  1  fabric back-pressure; blocks new grants.
ArbErrQ  out  1  sticky protocol error.

Behaviour:
- Reset (async, RstQnnnL=0): all outputs 0. Round-robin pointer = thread 0. All threads IDLE.
- Per-thread FSM, two states:
  - IDLE -> PENDING on grant.
  - PENDING -> IDLE on a response with matching ThreadID.
- Eligibility: ThReqValidQ500H[i]=1, thread i IDLE, C2F_RspStall=0, legal opcode.
- Grant selection: the first eligible thread searching from the pointer upward with wrap 3->0. At most one grant per cycle.
- Pointer update: on grant of thread i, pointer = (i+1) mod 4. No grant leaves the pointer unchanged.
- Launch: the granted request is registered. C2F_Req* is valid for exactly one cycle, at cycle N+1 after a grant at cycle N. When no grant, C2F_ReqValidQ500H=0 and all other C2F_Req* fields are 0.
- Stall:
  - C2F_RspStall=1 suppresses grants in that cycle.
  - A request already registered still launches.
  - Pending state is unaffected.
- Response handling, when C2F_RspValidQ502H=1 and thread t=C2F_RspThreadIDQ502H is PENDING:
  - ThRspValidQ502H[t]=1 and ThRspDataQ502H=C2F_RspDataQ502H, combinationally in the same cycle.
  - Thread t returns to IDLE next cycle.
  - Thread t is not eligible in the response cycle; it is eligible the following cycle.
- Opcode mismatch (response opcode differs from the stored request opcode): response is still delivered; ArbErrQ set.
- Response to an IDLE thread: dropped, no ThRspValid; ArbErrQ set.
- Illegal request opcode: never granted; ArbErrQ set while the request is asserted.
- ArbErrQ: sticky until reset.
- Simultaneous grant and response in one cycle are legal for different threads.
- Reset mid-transaction: all pending state is discarded; late fabric responses after reset set ArbErrQ.

Optional Feature:
Macro GPC_C2F_TIMEOUT_EN.
- Defined:
  - Per-thread 8-bit counter, cleared on grant, increments each PENDING cycle, saturates.
  - Reaching TMO_CYC forces the thread to IDLE, pulses ThRspValidQ502H[t] with data 32'hDEAD_BEEF, and sets ArbErrQ.
- Undefined: no counters; a thread stays PENDING indefinitely.

Test Plan:
- Reset, then all 4 threads request RD simultaneously with stall=0 -> grants in order T0,T1,T2,T3 on consecutive cycles; C2F_ReqThreadIDQ500H = 0,1,2,3 one cycle later each.
- T2 requests WR addr 32'h0040_0F04 data 32'h5 -> C2F_ReqValid one cycle after grant with opcode 10, address 32'h0040_0F04, data 32'h5; ThPendingQ=4'b0100 until a WR ack with ThreadID 2 returns; ThRspValidQ502H=4'b0100 on that ack.
- C2F_RspStall=1 for 5 cycles while T1 requests -> no grant for those 5 cycles; grant on the first cycle stall=0.
- T0 pending, response for T0 and new T0 request in the same cycle -> response delivered; T0 granted in the next cycle, not the same one.
- Response with ThreadID 3 while T3 is IDLE -> no ThRspValid; ArbErrQ=1 and remains 1 until reset.
- With GPC_C2F_TIMEOUT_EN defined, TMO_CYC=16, no response to T1 -> after 16 pending cycles ThRspValidQ502H=4'b0010 with data 32'hDEADBEEF, ArbErrQ=1, T1 grantable again.
